// File: rtl/pid_incremental_core.sv
// Velocity-form PID stage: u[n] = u[n-1] + k0*e[n] + k1*e[n-1] + k2*e[n-2].
// A single shared signed multiplier is stepped through the three taps by a small FSM.
module pid_incremental_core #(
  parameter int Width = 16,
  parameter int Frac  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    clr,
  input  logic signed [Width-1:0] e_in,
  input  logic signed [Width-1:0] k0,
  input  logic signed [Width-1:0] k1,
  input  logic signed [Width-1:0] k2,
  output logic                    busy,
  output logic                    done,
  output logic                    u_en,
  output logic signed [Width-1:0] u_out
);

  localparam int AccW = 2*Width + 2;
  localparam int RW   = AccW - Frac;

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, SAT} state_t;

  state_t                    state_reg;
  logic signed [Width-1:0]   e0_reg, e1_reg, e2_reg;
  logic signed [Width-1:0]   k0_reg, k1_reg, k2_reg;
  logic signed [Width-1:0]   u_reg;
  logic signed [AccW-1:0]    acc_reg;
  logic                      done_reg;

  logic signed [Width-1:0]   mul_a, mul_b;
  logic signed [2*Width-1:0] prod;
  logic signed [AccW-1:0]    prod_ext;
  logic signed [AccW-1:0]    acc_next;
  logic signed [AccW-1:0]    acc_init;
  logic signed [RW-1:0]      r;
  logic signed [Width-1:0]   u_next;

  // Operand select for the shared multiplier, one tap per MUL state.
  always_comb begin
    mul_a = k0_reg;
    mul_b = e0_reg;
    case (state_reg)
      MUL1: begin
        mul_a = k1_reg;
        mul_b = e1_reg;
      end
      MUL2: begin
        mul_a = k2_reg;
        mul_b = e2_reg;
      end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(AccW-2*Width){prod[2*Width-1]}}, prod};
  assign acc_next = acc_reg + prod_ext;
  assign acc_init = {{(AccW-Width-Frac){u_reg[Width-1]}}, u_reg, {Frac{1'b0}}};

  // Dropping the low Frac bits is an arithmetic shift, i.e. floor truncation.
  assign r = acc_reg[AccW-1:Frac];

  always_comb begin
    if (r[RW-1:Width-1] == '0 || r[RW-1:Width-1] == '1) begin
      u_next = r[Width-1:0];
    end else if (r[RW-1]) begin
      u_next = {1'b1, {(Width-1){1'b0}}};
    end else begin
      u_next = {1'b0, {(Width-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      e0_reg    <= '0;
      e1_reg    <= '0;
      e2_reg    <= '0;
      k0_reg    <= '0;
      k1_reg    <= '0;
      k2_reg    <= '0;
      u_reg     <= '0;
      acc_reg   <= '0;
      done_reg  <= 1'b0;
    end else if (clr) begin
      state_reg <= IDLE;
      e1_reg    <= '0;
      e2_reg    <= '0;
      u_reg     <= '0;
      acc_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            e0_reg    <= e_in;
            k0_reg    <= k0;
            k1_reg    <= k1;
            k2_reg    <= k2;
            acc_reg   <= acc_init;
            state_reg <= MUL0;
          end
        end
        MUL0: begin
          acc_reg   <= acc_next;
          state_reg <= MUL1;
        end
        MUL1: begin
          acc_reg   <= acc_next;
          state_reg <= MUL2;
        end
        MUL2: begin
          acc_reg   <= acc_next;
          state_reg <= SAT;
        end
        SAT: begin
          u_reg     <= u_next;
          e2_reg    <= e1_reg;
          e1_reg    <= e0_reg;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;
  assign u_en  = done_reg;
  assign u_out = u_reg;

endmodule

// File: tb/tb_pid_incremental_core.sv
// Bench for pid_incremental_core: directed vector table, multi-cycle corner
// sequences, and randomized samples checked against a plain-arithmetic model.
module tb_pid_incremental_core;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               clr = 1'b0;
  logic signed [15:0] e_in = '0;
  logic signed [15:0] k0 = '0;
  logic signed [15:0] k1 = '0;
  logic signed [15:0] k2 = '0;
  logic               busy, done, u_en;
  logic signed [15:0] u_out;

  pid_incremental_core #(.Width(16), .Frac(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .clr   (clr),
    .e_in  (e_in),
    .k0    (k0),
    .k1    (k1),
    .k2    (k2),
    .busy  (busy),
    .done  (done),
    .u_en  (u_en),
    .u_out (u_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint mu = 0, me1 = 0, me2 = 0;

  typedef struct {
    bit clr_first;
    int e;
    int a;
    int b;
    int c;
    int u;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: u = clamp(floor((u*2^8 + k0*e + k1*e1 + k2*e2) / 2^8)).
  task automatic model_step(input longint e, input longint a, input longint b, input longint c);
    longint acc;
    longint res;
    acc = mu * 256 + a * e + b * me1 + c * me2;
    res = acc >>> 8;
    if (res > 32767) res = 32767;
    if (res < -32768) res = -32768;
    mu  = res;
    me2 = me1;
    me1 = e;
  endtask

  task automatic model_zero;
    mu  = 0;
    me1 = 0;
    me2 = 0;
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_zero();
  endtask

  task automatic run_sample(input int e, input int a, input int b, input int c, output int u);
    int cyc;
    e_in  = 16'(e);
    k0    = 16'(a);
    k1    = 16'(b);
    k2    = 16'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", longint'(busy), 1);
    // Disturb inputs mid-operation; the core must use its latched copies.
    e_in = 16'($urandom);
    k0   = 16'($urandom);
    k1   = 16'($urandom);
    k2   = 16'($urandom);
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latency", cyc, 4);
    chk("u_en_eq_done", longint'(u_en), longint'(done));
    u = int'(u_out);
    model_step(e, a, b, c);
    $display("sample e=%0d k=(%0d,%0d,%0d) u_out=%0d", e, a, b, c, u);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u;
    int cnt;
    int e, a, b, c;

    tbl[0]  = '{1, 100, 256, 0, 0, 100};
    tbl[1]  = '{0, 100, 256, 0, 0, 200};
    tbl[2]  = '{1, 50, 256, -256, 0, 50};
    tbl[3]  = '{0, 50, 256, -256, 0, 50};
    tbl[4]  = '{0, 80, 256, -256, 0, 80};
    tbl[5]  = '{1, 32767, 32767, 0, 0, 32767};
    tbl[6]  = '{0, -32768, 32767, 0, 0, -32768};
    tbl[7]  = '{1, -1, 128, 0, 0, -1};
    tbl[8]  = '{1, 1, 128, 0, 0, 0};
    tbl[9]  = '{1, 10, 0, 0, 256, 0};
    tbl[10] = '{0, 20, 0, 0, 256, 0};
    tbl[11] = '{0, 30, 0, 0, 256, 10};

    // Reset state held with no start.
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("reset_u_out", longint'(u_out), 0);
      chk("reset_busy", longint'(busy), 0);
      chk("reset_done", longint'(done), 0);
    end

    // Directed vector table (back-to-back starts within each group).
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].clr_first) do_clr();
      run_sample(tbl[i].e, tbl[i].a, tbl[i].b, tbl[i].c, u);
      chk($sformatf("vec%0d", i), u, tbl[i].u);
    end

    // Start during MUL1 is ignored: exactly one done.
    do_clr();
    e_in = 16'(5); k0 = 16'(256); k1 = '0; k2 = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    e_in = 16'(99);
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) cnt++;
    end
    chk("start_in_mul1_dones", cnt, 1);
    chk("start_in_mul1_u", longint'(u_out), 5);
    $display("sample start-during-MUL1 u_out=%0d dones=%0d", u_out, cnt);
    model_step(5, 256, 0, 0);

    // Clear during MUL2 aborts with no done pulse.
    e_in = 16'(7); k0 = 16'(256);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_zero();
    chk("clr_mul2_done_now", longint'(done), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) cnt++;
    end
    chk("clr_mul2_dones", cnt, 0);
    chk("clr_mul2_u", longint'(u_out), 0);
    chk("clr_mul2_busy", longint'(busy), 0);
    $display("sample clr-during-MUL2 u_out=%0d dones=%0d", u_out, cnt);

    // Reset asserted in SAT: back to reset values, no done.
    run_sample(9, 256, 0, 0, u);
    chk("pre_reset_u", u, 9);
    e_in = 16'(20);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("reset_sat_u_async", longint'(u_out), 0);
    chk("reset_sat_busy", longint'(busy), 0);
    tick();
    rst_n = 1'b1;
    model_zero();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) cnt++;
    end
    chk("reset_sat_dones", cnt, 0);
    chk("reset_sat_u", longint'(u_out), 0);
    $display("sample reset-during-SAT u_out=%0d dones=%0d", u_out, cnt);

    // Randomized samples against the reference model.
    for (int i = 0; i < 60; i++) begin
      if (i % 15 == 0) do_clr();
      if ($urandom_range(0, 3) == 0) begin
        e = int'($signed(16'($urandom)));
        a = int'($signed(16'($urandom)));
        b = int'($signed(16'($urandom)));
        c = int'($signed(16'($urandom)));
      end else begin
        e = int'($urandom_range(0, 1024)) - 512;
        a = int'($urandom_range(0, 1024)) - 512;
        b = int'($urandom_range(0, 1024)) - 512;
        c = int'($urandom_range(0, 1024)) - 512;
      end
      run_sample(e, a, b, c, u);
      chk($sformatf("rand%0d", i), u, mu);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
